alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_if.sv | 57 +++++
 rtl/alu_issue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// Handshake bus for alu_issue: the instruction side (in_*) and the
// ALU command side (out_*), plus the shared opcode/width encodings.
`ifndef ALU_ISSUE_DEFS
`define ALU_ISSUE_DEFS
`define instWidth 32
`define aluOP     5
`define aluPlus   5'd0
`define aluMinus  5'd1
`define aluSLL    5'd2
`define aluSLT    5'd3
`define aluSLTU   5'd4
`define aluXOR    5'd5
`define aluSRL    5'd6
`define aluSRA    5'd7
`define aluOR     5'd8
`define aluAND    5'd9
`define aluMUL    5'd10
`define aluBEQ    5'd11
`define aluBNE    5'd12
`define aluBLT    5'd13
`define aluBGE    5'd14
`define aluLUI    5'd15
`define aluAUIPC  5'd16
`endif

interface alu_issue_if;
    logic                  in_valid;
    logic                  in_ready;
    logic [`instWidth-1:0] in_inst;
    logic [`instWidth-1:0] in_pc;
    logic [`instWidth-1:0] in_rs1;
    logic [`instWidth-1:0] in_rs2;

    logic                  out_valid;
    logic                  out_ready;
    logic [`aluOP-1:0]     out_aluop;
    logic [`instWidth-1:0] out_src1;
    logic [`instWidth-1:0] out_src2;
    logic [`instWidth-1:0] out_pc;
    logic [4:0]            out_rd;
    logic                  out_we;
    logic [`instWidth-1:0] out_boff;

    // Issue block side: consumes instructions, produces ALU commands.
    modport slave (
        input  in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
        output in_ready, out_valid, out_aluop, out_src1, out_src2,
               out_pc, out_rd, out_we, out_boff
    );

    // Driver side: presents instructions and accepts ALU commands.
    modport master (
        output in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
        input  in_ready, out_valid, out_aluop, out_src1, out_src2,
               out_pc, out_rd, out_we, out_boff
    );
endinterface

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an RV32 instruction at acceptance into an ALU
// command and buffers it in a 2-entry FIFO. in_ready depends only on the
// registered occupancy, so there is no combinational in->out path.
module alu_issue #(
    parameter int ILLEGAL_DROP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    output logic         illegal,
    alu_issue_if.slave   bus
);

    localparam bit DROP = (ILLEGAL_DROP != 0);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef struct packed {
        logic [`aluOP-1:0]     aluop;
        logic [`instWidth-1:0] src1;
        logic [`instWidth-1:0] src2;
        logic [`instWidth-1:0] pc;
        logic [4:0]            rd;
        logic                  we;
        logic [`instWidth-1:0] boff;
    } cmd_t;

    // Instruction fields and immediates
    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic [6:0]            w_funct7;
    logic [4:0]            w_rd;
    logic [`instWidth-1:0] w_imm_i;
    logic [`instWidth-1:0] w_shamt;
    logic [`instWidth-1:0] w_imm_b;
    logic [`instWidth-1:0] w_imm_u;

    assign w_opcode = bus.in_inst[6:0];
    assign w_rd     = bus.in_inst[11:7];
    assign w_funct3 = bus.in_inst[14:12];
    assign w_funct7 = bus.in_inst[31:25];
    assign w_imm_i  = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
    assign w_shamt  = {27'b0, bus.in_inst[24:20]};
    assign w_imm_b  = {{19{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[7],
                       bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
    assign w_imm_u  = {bus.in_inst[31:12], 12'b0};

    logic w_legal;
    cmd_t w_cmd;
    cmd_t w_entry;

    // Decode the presented instruction into a command and a legality flag
    always_comb begin
        w_legal       = 1'b0;
        w_cmd         = '0;
        w_cmd.aluop   = `aluPlus;
        w_cmd.pc      = bus.in_pc;
        case (w_opcode)
            OPC_OP: begin
                w_cmd.src1 = bus.in_rs1;
                w_cmd.src2 = bus.in_rs2;
                w_cmd.rd   = w_rd;
                w_cmd.we   = 1'b1;
                w_legal    = 1'b1;
                case ({w_funct7, w_funct3})
                    {F7_ZERO, 3'b000}: w_cmd.aluop = `aluPlus;
                    {F7_ALT,  3'b000}: w_cmd.aluop = `aluMinus;
                    {F7_ZERO, 3'b001}: w_cmd.aluop = `aluSLL;
                    {F7_ZERO, 3'b010}: w_cmd.aluop = `aluSLT;
                    {F7_ZERO, 3'b011}: w_cmd.aluop = `aluSLTU;
                    {F7_ZERO, 3'b100}: w_cmd.aluop = `aluXOR;
                    {F7_ZERO, 3'b101}: w_cmd.aluop = `aluSRL;
                    {F7_ALT,  3'b101}: w_cmd.aluop = `aluSRA;
                    {F7_ZERO, 3'b110}: w_cmd.aluop = `aluOR;
                    {F7_ZERO, 3'b111}: w_cmd.aluop = `aluAND;
                    {F7_MUL,  3'b000}: w_cmd.aluop = `aluMUL;
                    default:           w_legal     = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                w_cmd.src1 = bus.in_rs1;
                w_cmd.src2 = w_imm_i;
                w_cmd.rd   = w_rd;
                w_cmd.we   = 1'b1;
                w_legal    = 1'b1;
                case (w_funct3)
                    3'b000: w_cmd.aluop = `aluPlus;
                    3'b010: w_cmd.aluop = `aluSLT;
                    3'b011: w_cmd.aluop = `aluSLTU;
                    3'b100: w_cmd.aluop = `aluXOR;
                    3'b110: w_cmd.aluop = `aluOR;
                    3'b111: w_cmd.aluop = `aluAND;
                    3'b001: begin
                        w_cmd.src2  = w_shamt;
                        w_cmd.aluop = `aluSLL;
                        w_legal     = (w_funct7 == F7_ZERO);
                    end
                    default: begin
                        // 101: SRLI / SRAI, distinguished by inst[30]
                        w_cmd.src2  = w_shamt;
                        w_cmd.aluop = bus.in_inst[30] ? `aluSRA : `aluSRL;
                        w_legal     = (w_funct7 == F7_ZERO) || (w_funct7 == F7_ALT);
                    end
                endcase
            end
            OPC_BRANCH: begin
                // Branches never write back; rd stays 0
                w_cmd.src1 = bus.in_rs1;
                w_cmd.src2 = bus.in_rs2;
                w_cmd.boff = w_imm_b;
                w_legal    = 1'b1;
                case (w_funct3)
                    3'b000:  w_cmd.aluop = `aluBEQ;
                    3'b001:  w_cmd.aluop = `aluBNE;
                    3'b100:  w_cmd.aluop = `aluBLT;
                    3'b101:  w_cmd.aluop = `aluBGE;
                    default: w_legal     = 1'b0;
                endcase
            end
            OPC_LUI: begin
                w_cmd.src2  = w_imm_u;
                w_cmd.aluop = `aluLUI;
                w_cmd.rd    = w_rd;
                w_cmd.we    = 1'b1;
                w_legal     = 1'b1;
            end
            OPC_AUIPC: begin
                w_cmd.src2  = w_imm_u;
                w_cmd.aluop = `aluAUIPC;
                w_cmd.rd    = w_rd;
                w_cmd.we    = 1'b1;
                w_legal     = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Illegal instructions that are kept become a harmless add with no writeback
    always_comb begin
        w_entry = w_cmd;
        if (!w_legal) begin
            w_entry       = '0;
            w_entry.aluop = `aluPlus;
            w_entry.pc    = bus.in_pc;
        end
    end

    // FIFO bookkeeping
    logic [1:0] r_count;
    logic       r_wptr;
    logic       r_rptr;
    logic       r_illegal;
    cmd_t       r_mem [2];

    logic w_acc;
    logic w_push;
    logic w_pop;

    assign bus.in_ready  = (r_count != 2'd2);
    assign bus.out_valid = (r_count != 2'd0);

    assign w_acc  = bus.in_valid && bus.in_ready;
    assign w_push = w_acc && !flush && (w_legal || !DROP);
    assign w_pop  = bus.out_valid && bus.out_ready && !flush;

    // Occupancy, pointers and the illegal pulse; flush wins over push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= 2'd0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_count   <= 2'd0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_acc && !w_legal;
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the idle outputs read as an add of zeros
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    // Outputs always show the head entry
    cmd_t w_head;
    assign w_head        = r_mem[r_rptr];
    assign bus.out_aluop = w_head.aluop;
    assign bus.out_src1  = w_head.src1;
    assign bus.out_src2  = w_head.src2;
    assign bus.out_pc    = w_head.pc;
    assign bus.out_rd    = w_head.rd;
    assign bus.out_we    = w_head.we;
    assign bus.out_boff  = w_head.boff;
    assign illegal       = r_illegal;

endmodule
